// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared types and register-bus widths for the register-file write-port arbiter.
package regfile_wport_arbiter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } arb_state_e;

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// Write-port bus: primary writer, secondary writer, register-file port and hazard queries.
interface regfile_wport_arbiter_if #(
    parameter int unsigned DATA_W = regfile_wport_arbiter_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_wport_arbiter_pkg::ADDR_W
);
    logic              P_WEN;
    logic [ADDR_W-1:0] P_WADDR;
    logic [DATA_W-1:0] P_WDATA;
    logic              S_VALID;
    logic              S_READY;
    logic [ADDR_W-1:0] S_WADDR;
    logic [DATA_W-1:0] S_WDATA;
    logic              WEN;
    logic [ADDR_W-1:0] WADDR;
    logic [DATA_W-1:0] WDATA;
    logic              STALL_REQ;
    logic [ADDR_W-1:0] Q_ADDR1;
    logic [ADDR_W-1:0] Q_ADDR2;
    logic              Q_HIT1;
    logic              Q_HIT2;

    modport master (
        output P_WEN, P_WADDR, P_WDATA, S_VALID, S_WADDR, S_WDATA, Q_ADDR1, Q_ADDR2,
        input  S_READY, WEN, WADDR, WDATA, STALL_REQ, Q_HIT1, Q_HIT2
    );

    modport slave (
        input  P_WEN, P_WADDR, P_WDATA, S_VALID, S_WADDR, S_WDATA, Q_ADDR1, Q_ADDR2,
        output S_READY, WEN, WADDR, WDATA, STALL_REQ, Q_HIT1, Q_HIT2
    );

endinterface

// File: rtl/regfile_wbuf_fifo.sv
// Synchronous FIFO of buffered secondary writes; exposes per-slot valid/address for hazard checks.
module regfile_wbuf_fifo
    import regfile_wport_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  wr_req_t                        din_i,
    output wr_req_t                        head_o,
    output logic                           empty_o,
    output logic                           full_o,
    output logic [DEPTH-1:0]               ent_valid_o,
    output logic [DEPTH-1:0][ADDR_W-1:0]   ent_addr_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    wr_req_t          mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W-1:0] offs;

    always_ff @(posedge CLK) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        offs        = '0;
        ent_valid_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offs           = PTR_W'(i) - rd_ptr_q;
            ent_valid_o[i] = ({1'b0, offs} < count_q);
            ent_addr_o[i]  = mem_q[i].addr;
        end
    end

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Arbitrates the single register-file write port: primary writeback wins, secondary writes are
// buffered, and a starvation counter forces a one-cycle stall so the buffer head can drain.
module regfile_wport_arbiter #(
    parameter int unsigned DATA_W     = regfile_wport_arbiter_pkg::DATA_W,
    parameter int unsigned ADDR_W     = regfile_wport_arbiter_pkg::ADDR_W,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    regfile_wport_arbiter_if.slave  bus
);
    import regfile_wport_arbiter_pkg::*;

    localparam int unsigned CNT_W = $clog2(STARVE_MAX) + 1;

    arb_state_e                          state_q, state_d;
    logic [CNT_W-1:0]                    starve_q, starve_d;
    wr_req_t                             head, s_req;
    logic                                empty, full, push, pop;
    logic                                p_valid, head_blocked, s_ready;
    logic                                wen;
    logic [ADDR_W-1:0]                   waddr;
    logic [DATA_W-1:0]                   wdata;
    logic                                hit1, hit2;
    logic [FIFO_DEPTH-1:0]               ent_valid;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0]   ent_addr;

    assign p_valid = bus.P_WEN && (bus.P_WADDR != '0);
    assign s_req   = '{addr: bus.S_WADDR, data: bus.S_WDATA};
    assign s_ready = !full && !RST;
    // Writes to $0 complete the handshake but never occupy a slot.
    assign push    = bus.S_VALID && s_ready && (bus.S_WADDR != '0);

    regfile_wbuf_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK         (CLK),
        .RST         (RST),
        .push_i      (push),
        .pop_i       (pop),
        .din_i       (s_req),
        .head_o      (head),
        .empty_o     (empty),
        .full_o      (full),
        .ent_valid_o (ent_valid),
        .ent_addr_o  (ent_addr)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = IDLE;
        starve_d = starve_q;
        if (pop || empty) begin
            starve_d = '0;
        end else if (head_blocked) begin
            starve_d = starve_q + 1'b1;
        end
        if ((state_q == IDLE) && head_blocked && (starve_q == CNT_W'(STARVE_MAX - 1))) begin
            state_d = DRAIN;
        end
    end

    always_comb begin
        pop          = 1'b0;
        head_blocked = 1'b0;
        wen          = 1'b0;
        waddr        = '0;
        wdata        = '0;
        if (!RST) begin
            if (state_q == DRAIN) begin
                if (!empty) begin
                    pop   = 1'b1;
                    wen   = 1'b1;
                    waddr = head.addr;
                    wdata = head.data;
                end
            end else if (p_valid) begin
                wen          = 1'b1;
                waddr        = bus.P_WADDR;
                wdata        = bus.P_WDATA;
                head_blocked = !empty;
            end else if (!empty) begin
                pop   = 1'b1;
                wen   = 1'b1;
                waddr = head.addr;
                wdata = head.data;
            end
        end
    end

    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            hit1 = hit1 | (ent_valid[i] && (ent_addr[i] == bus.Q_ADDR1));
            hit2 = hit2 | (ent_valid[i] && (ent_addr[i] == bus.Q_ADDR2));
        end
        if (RST || (bus.Q_ADDR1 == '0)) hit1 = 1'b0;
        if (RST || (bus.Q_ADDR2 == '0)) hit2 = 1'b0;
    end

    assign bus.S_READY   = s_ready;
    assign bus.WEN       = wen;
    assign bus.WADDR     = waddr;
    assign bus.WDATA     = wdata;
    assign bus.STALL_REQ = (state_q == DRAIN);
    assign bus.Q_HIT1    = hit1;
    assign bus.Q_HIT2    = hit2;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench: queue-based reference model plus directed scenarios and random traffic.
module tb_regfile_wport_arbiter;

    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    regfile_wport_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regfile_wport_arbiter #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .FIFO_DEPTH (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    int   streak  = 0;
    bit   m_drain = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic        obs_wen, obs_stall, obs_sready, obs_hit1, obs_hit2;
    logic [4:0]  obs_waddr;
    logic [31:0] obs_wdata;

    task automatic drive(input logic pwen, input logic [4:0] paddr, input logic [31:0] pdata,
                         input logic svalid, input logic [4:0] saddr, input logic [31:0] sdata);
        bus.P_WEN   = pwen;
        bus.P_WADDR = paddr;
        bus.P_WDATA = pdata;
        bus.S_VALID = svalid;
        bus.S_WADDR = saddr;
        bus.S_WDATA = sdata;
    endtask

    // One clock: compare DUT against the model at negedge, then advance the model at posedge.
    task automatic run_cycle(input string tag);
        logic        pv, e_wen, e_sr, e_h1, e_h2, e_st;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        bit          do_pop, blocked, nd, was_empty;
        @(negedge CLK);
        pv     = bus.P_WEN && (bus.P_WADDR != 5'd0);
        e_wen  = 1'b0;
        e_addr = '0;
        e_data = '0;
        do_pop = 1'b0;
        if (!RST) begin
            if (m_drain && mq.size() > 0) begin
                e_wen = 1'b1; e_addr = mq[0].a; e_data = mq[0].d; do_pop = 1'b1;
            end else if (!m_drain && pv) begin
                e_wen = 1'b1; e_addr = bus.P_WADDR; e_data = bus.P_WDATA;
            end else if (!m_drain && mq.size() > 0) begin
                e_wen = 1'b1; e_addr = mq[0].a; e_data = mq[0].d; do_pop = 1'b1;
            end
        end
        e_sr = !RST && (mq.size() < DEPTH);
        e_h1 = 1'b0;
        e_h2 = 1'b0;
        foreach (mq[k]) begin
            if (mq[k].a == bus.Q_ADDR1) e_h1 = 1'b1;
            if (mq[k].a == bus.Q_ADDR2) e_h2 = 1'b1;
        end
        if (RST || bus.Q_ADDR1 == 5'd0) e_h1 = 1'b0;
        if (RST || bus.Q_ADDR2 == 5'd0) e_h2 = 1'b0;
        e_st = m_drain;

        obs_wen    = bus.WEN;
        obs_waddr  = bus.WADDR;
        obs_wdata  = bus.WDATA;
        obs_stall  = bus.STALL_REQ;
        obs_sready = bus.S_READY;
        obs_hit1   = bus.Q_HIT1;
        obs_hit2   = bus.Q_HIT2;

        n_checks++;
        if (obs_wen !== e_wen) begin
            n_errors++; $display("FAIL %s wen: got %b want %b", tag, obs_wen, e_wen);
        end
        n_checks++;
        if (obs_stall !== e_st) begin
            n_errors++; $display("FAIL %s stall_req: got %b want %b", tag, obs_stall, e_st);
        end
        n_checks++;
        if (obs_sready !== e_sr) begin
            n_errors++; $display("FAIL %s s_ready: got %b want %b", tag, obs_sready, e_sr);
        end
        n_checks++;
        if (obs_hit1 !== e_h1) begin
            n_errors++; $display("FAIL %s q_hit1: got %b want %b", tag, obs_hit1, e_h1);
        end
        n_checks++;
        if (obs_hit2 !== e_h2) begin
            n_errors++; $display("FAIL %s q_hit2: got %b want %b", tag, obs_hit2, e_h2);
        end
        if (!RST) begin
            n_checks++;
            if (obs_waddr !== e_addr || obs_wdata !== e_data) begin
                n_errors++;
                $display("FAIL %s waddr/wdata: got %0d/%h want %0d/%h",
                         tag, obs_waddr, obs_wdata, e_addr, e_data);
            end
        end

        @(posedge CLK);
        if (RST) begin
            mq.delete();
            streak  = 0;
            m_drain = 1'b0;
        end else begin
            was_empty = (mq.size() == 0);
            blocked   = !m_drain && !was_empty && pv;
            nd        = blocked && (streak == SMAX - 1);
            if (do_pop || was_empty) streak = 0;
            else if (blocked)        streak++;
            if (do_pop) void'(mq.pop_front());
            if (bus.S_VALID && e_sr && bus.S_WADDR != 5'd0)
                mq.push_back('{a: bus.S_WADDR, d: bus.S_WDATA});
            m_drain = nd;
        end
        #1;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        bus.Q_ADDR1 = 5'd0;
        bus.Q_ADDR2 = 5'd0;
        for (int i = 0; i < n; i++) run_cycle("idle");
    endtask

    task automatic test_reset;
        drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd4, 32'h44);
        run_cycle("rst_fill");
        RST = 1'b1;
        drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd8, 32'h88);
        run_cycle("rst_active");
        n_checks++;
        if (obs_wen !== 1'b0 || obs_sready !== 1'b0) begin
            n_errors++; $display("FAIL rst_outputs: wen=%b s_ready=%b want 0/0", obs_wen, obs_sready);
        end
        RST = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        bus.Q_ADDR1 = 5'd4;
        run_cycle("rst_after");
        n_checks++;
        if (obs_hit1 !== 1'b0 || obs_wen !== 1'b0 || obs_stall !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_flush: hit1=%b wen=%b stall=%b want 0/0/0", obs_hit1, obs_wen, obs_stall);
        end
    endtask

    task automatic test_idle_secondary;
        idle(2);
        bus.Q_ADDR1 = 5'd7;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEADBEEF);
        run_cycle("sec_c0");
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        run_cycle("sec_c1");
        n_checks++;
        if (obs_wen !== 1'b1 || obs_waddr !== 5'd7 || obs_wdata !== 32'hDEADBEEF || obs_hit1 !== 1'b1) begin
            n_errors++;
            $display("FAIL sec_write: wen=%b addr=%0d data=%h hit1=%b want 1/7/deadbeef/1",
                     obs_wen, obs_waddr, obs_wdata, obs_hit1);
        end
        run_cycle("sec_c2");
        n_checks++;
        if (obs_hit1 !== 1'b0) begin
            n_errors++; $display("FAIL sec_hit_clear: got %b want 0", obs_hit1);
        end
    endtask

    task automatic test_primary_priority;
        idle(2);
        bus.Q_ADDR2 = 5'd3;
        drive(1'b1, 5'd5, 32'h22, 1'b1, 5'd3, 32'h11);
        run_cycle("pri_c0");
        drive(1'b1, 5'd5, 32'h22, 1'b0, 5'd0, 32'd0);
        run_cycle("pri_c1");
        n_checks++;
        if (obs_waddr !== 5'd5 || obs_wdata !== 32'h22 || obs_hit2 !== 1'b1) begin
            n_errors++;
            $display("FAIL pri_wins: addr=%0d data=%h hit2=%b want 5/22/1", obs_waddr, obs_wdata, obs_hit2);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        run_cycle("pri_c2");
        n_checks++;
        if (obs_waddr !== 5'd3 || obs_wdata !== 32'h11) begin
            n_errors++; $display("FAIL pri_head_kept: addr=%0d data=%h want 3/11", obs_waddr, obs_wdata);
        end
    endtask

    task automatic test_starvation;
        logic [5:0] stalls;
        idle(2);
        drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd12, 32'hC0C0);
        run_cycle("stv_push");
        drive(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'd0);
        for (int k = 0; k < 6; k++) begin
            run_cycle("stv");
            stalls[k] = obs_stall;
            if (k == 4) begin
                n_checks++;
                if (obs_waddr !== 5'd12 || obs_wdata !== 32'hC0C0) begin
                    n_errors++;
                    $display("FAIL stv_drain_head: addr=%0d data=%h want 12/c0c0", obs_waddr, obs_wdata);
                end
            end
        end
        n_checks++;
        if (stalls !== 6'b010000) begin
            n_errors++; $display("FAIL stv_stall_pattern: got %b want 010000", stalls);
        end
    endtask

    task automatic test_full_zero;
        idle(2);
        bus.Q_ADDR1 = 5'd10;
        drive(1'b1, 5'd5, 32'h1, 1'b1, 5'd9, 32'h9);
        run_cycle("full_c0");
        drive(1'b1, 5'd5, 32'h2, 1'b1, 5'd10, 32'hA);
        run_cycle("full_c1");
        drive(1'b1, 5'd5, 32'h3, 1'b1, 5'd11, 32'hB);
        run_cycle("full_c2");
        n_checks++;
        if (obs_sready !== 1'b0) begin
            n_errors++; $display("FAIL full_sready: got %b want 0", obs_sready);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'hB);
        run_cycle("full_c3");
        n_checks++;
        if (obs_sready !== 1'b0 || obs_waddr !== 5'd9) begin
            n_errors++; $display("FAIL full_nobypass: s_ready=%b addr=%0d want 0/9", obs_sready, obs_waddr);
        end
        drive(1'b1, 5'd5, 32'h4, 1'b1, 5'd0, 32'hF);
        run_cycle("zero_c4");
        drive(1'b1, 5'd5, 32'h5, 1'b0, 5'd0, 32'd0);
        run_cycle("zero_c5");
        n_checks++;
        if (obs_sready !== 1'b1 || obs_hit1 !== 1'b1) begin
            n_errors++; $display("FAIL zero_discard: s_ready=%b hit1=%b want 1/1", obs_sready, obs_hit1);
        end
        idle(3);
    endtask

    task automatic test_back_to_back;
        logic [4:0]  seen_a [6];
        logic [31:0] seen_d [6];
        idle(2);
        for (int i = 1; i <= 7; i++) begin
            if (i <= 6) drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'(i * 256));
            else        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            run_cycle("wrap");
            if (i >= 2) begin
                seen_a[i-2] = obs_waddr;
                seen_d[i-2] = obs_wdata;
            end
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (seen_a[i] !== 5'(i + 1) || seen_d[i] !== 32'((i + 1) * 256)) begin
                n_errors++;
                $display("FAIL wrap_order[%0d]: got %0d/%h want %0d/%h",
                         i, seen_a[i], seen_d[i], i + 1, (i + 1) * 256);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            RST = ($urandom_range(0, 79) == 0);
            drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom);
            bus.Q_ADDR1 = 5'($urandom_range(0, 7));
            bus.Q_ADDR2 = 5'($urandom_range(0, 7));
            run_cycle("rand");
        end
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'd0);
        bus.Q_ADDR1 = 5'd0;
        bus.Q_ADDR2 = 5'd0;
        run_cycle("init_rst");
        run_cycle("init_rst");
        RST = 1'b0;
        idle(1);
        test_reset;
        test_idle_secondary;
        test_primary_priority;
        test_starvation;
        test_full_zero;
        test_back_to_back;
        test_random;
        idle(4);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the register file's single write port between two writers: the pipeline writeback stage (primary) and a long-latency unit such as the divider or a load-miss return (secondary).
- The primary writer always wins. Secondary writes wait in a small FIFO.
- A starvation counter forces a one-cycle pipeline stall so the FIFO head can drain.
- Pending-write query ports let decode detect RAW hazards on buffered writes.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- FIFO_DEPTH, 2, secondary buffer entries (power of 2, ≥2).
- STARVE_MAX, 4, consecutive blocked cycles before a forced drain (≥1).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- P_WEN  in  1  primary write request.
- P_WADDR  in  ADDR_W  primary destination register.
- P_WDATA  in  DATA_W  primary data.
- S_VALID  in  1  secondary write offered.
- S_READY  out  1  secondary accepted this cycle.
- S_WADDR  in  ADDR_W  secondary destination register.
- S_WDATA  in  DATA_W  secondary data.
- WEN  out  1  register file write enable.
- WADDR  out  ADDR_W  register file write address.
- WDATA  out  DATA_W  register file write data.
- STALL_REQ  out  1  registered stall request to the pipeline controller.
- Q_ADDR1  in  ADDR_W  hazard query address, read port 1.
- Q_ADDR2  in  ADDR_W  hazard query address, read port 2.
- Q_HIT1  out  1  Q_ADDR1 has a pending buffered write.
- Q_HIT2  out  1  Q_ADDR2 has a pending buffered write.

Behaviour:
- Reset (RST=1 at a posedge):
  - FIFO emptied, counter=0, state IDLE.
  - STALL_REQ=0.
  - While RST=1, combinationally: WEN=0, S_READY=0, Q_HIT*=0.
  - Reset mid-operation discards all buffered writes.
- Primary valid = P_WEN && P_WADDR!=0. A write to $0 is never driven onto WEN.
- Grant (combinational, zero latency):
  - IDLE: primary valid → WEN=1 with P_WADDR/P_WDATA. Otherwise, FIFO non-empty → WEN=1 with head entry, dequeue at posedge. Otherwise WEN=0, WADDR=0, WDATA=0.
  - DRAIN: FIFO head is always granted. P_WEN is ignored; the pipeline contract is P_WEN=0 while STALL_REQ=1.
- Enqueue:
  - S_READY = !full && !RST.
  - An entry is pushed at posedge when S_VALID && S_READY && S_WADDR!=0.
  - S_WADDR==0 is accepted (S_READY handshake completes) but discarded.
  - When full, S_READY=0 even if a dequeue happens the same cycle; no bypass.
  - Simultaneous push and pop when not full: count unchanged, order preserved.
  - An incoming secondary write is never forwarded straight to WEN in its arrival cycle. Minimum latency is 1 cycle.
- Pointers: rd/wr pointers wrap modulo FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH.
- Starvation counter (width clog2(STARVE_MAX)+1):
  - In IDLE, increments when FIFO non-empty and head not granted.
  - Clears on any dequeue or when FIFO empty.
- FSM IDLE→DRAIN at posedge when FIFO non-empty, head blocked this cycle, and counter==STARVE_MAX-1.
- In DRAIN: STALL_REQ=1 (a registered output equal to state==DRAIN); head dequeued that cycle; next state IDLE; counter cleared.
- STALL_REQ is therefore exactly one cycle per forced drain.
- Hazard query: Q_HITn = OR over valid FIFO entries of (entry.addr==Q_ADDRn). Q_ADDRn==0 gives 0. Combinational, reflecting FIFO contents before this cycle's push/pop.
- Ordering: decode must stall on Q_HIT before issuing a primary write to the same register. The block does not reorder or merge same-address writes.

Decomposition:
- Shared package holds:
  - wr_req_t struct {addr, data}.
  - arb_state_e enum {IDLE, DRAIN}.
  - Constants DATA_W/ADDR_W tied to the existing register-bus defines.
- One sub-module: regfile_wbuf_fifo (sync FIFO of wr_req_t exposing entry-valid and address vectors for the hazard compare). Arbitration, starvation logic and FSM live in the top module.

Test Plan:
- Reset: assert RST with S_VALID=1 and FIFO holding 1 entry → next cycle WEN=0, STALL_REQ=0, S_READY=0 during RST, FIFO empty (Q_HIT1=0 for the old address) after release.
- Idle secondary: S_VALID=1, S_WADDR=7, S_WDATA=0xDEADBEEF, P_WEN=0 → accepted at cycle 0, Q_HIT1=1 for Q_ADDR1=7 in cycle 1, WEN=1 WADDR=7 WDATA=0xDEADBEEF in cycle 1, Q_HIT1=0 in cycle 2.
- Primary priority: FIFO holds {3,0x11}, P_WEN=1 P_WADDR=5 P_WDATA=0x22 → WEN writes 5/0x22, FIFO head retained, counter increments.
- Starvation: FIFO non-empty, P_WEN=1 continuously, STARVE_MAX=4 → STALL_REQ=1 in the 5th cycle, head written that cycle with P_WEN ignored, STALL_REQ=0 next cycle.
- Full/$0: push addrs 9,10 with no drain (primary busy) → S_READY=0 when full; S_WADDR=0 push when not full → handshake completes, occupancy unchanged.
- Wrap-around: 6 back-to-back secondary writes (addrs 1..6, data=addr*0x100) with P_WEN=0 → WEN sequence 1..6 in order with correct data, pointers wrap twice.
